// File: rtl/spi_pkg.sv
// Shared SPI framing definitions for the FPGA transmitter and the slave receiver.
// Holds the link mode (CPOL=1, CPHA=1, MSB first), the default frame and payload
// widths, and the one-hot FSM state encoding. Both ends use this package, so they
// agree on how a frame is delimited and counted.
package spi_pkg;

   localparam logic CPOL = 1'b1;
   localparam logic CPHA = 1'b1;

   localparam int unsigned FRAME_BITS_DEF  = 16;
   localparam int unsigned DATA_W_DEF      = 12;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   // One-hot frame state.
   typedef enum logic [2:0] {
      StIdle   = 3'b001,
      StActive = 3'b010,
      StDone   = 3'b100
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by rise/fall detection.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high; presets the chain to RESET_VAL
//   din   in   asynchronous pin
//   dout  out  synchronized level
//   rise  out  1-cycle strobe: dout went 0 -> 1
//   fall  out  1-cycle strobe: dout went 1 -> 0
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         dly_q  <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      dout = sync_q[SYNC_STAGES-1];
      rise = sync_q[SYNC_STAGES-1] & ~dly_q;
      fall = ~sync_q[SYNC_STAGES-1] & dly_q;
   end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 3, MSB first, active-low frame select).
// Oversamples sck/mosi/nc on clk, deserializes one frame per nc-low window and
// presents the last DATA_W bits on a valid/ready handshake.
// Ports:
//   clk        in   system clock, at least 4x sck
//   rst        in   synchronous reset, active-high
//   sck        in   SPI clock (async, idles high)
//   mosi       in   SPI data (async)
//   nc         in   frame select (async, active-low)
//   rx_data    out  received payload, stable while rx_valid=1
//   rx_valid   out  payload available, held until accepted
//   rx_ready   in   consumer accepts when rx_valid & rx_ready
//   frame_err  out  1-cycle pulse on short frame or extra sck edges
//   overrun    out  sticky: a frame completed while a word was still pending
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              mosi,
   input  logic              nc,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overrun
);

   localparam int unsigned CNT_W   = $clog2(FRAME_BITS + 1);
   localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(FRAME_BITS);
   localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

   if (FRAME_BITS < DATA_W) begin : g_bad_frame
      $error("spi_slave_rx: FRAME_BITS must be >= DATA_W");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_slave_rx: SYNC_STAGES must be >= 2");
   end

   logic sck_s, sck_rise, sck_fall;
   logic nc_s, nc_rise, nc_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   mosi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sck),
      .dout (sck_s),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nc_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (nc),
      .dout (nc_s),
      .rise (nc_rise),
      .fall (nc_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) mosi_sync_q <= '0;
      else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              commit_q, commit_d;
   logic              frame_err_q, frame_err_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;
   logic              armed_q, armed_d;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q, overrun_q;

   // After reset the synchronizers hold preset values, not the pin. Frame start is only
   // honoured once the chain has flushed and nc has been seen high, so a frame already
   // running at reset release is skipped until its nc rises.
   always_comb begin
      flush_d = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 1'b1;
      armed_d = armed_q | ((flush_q == FLUSH_DONE) & nc_s);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      commit_d    = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (nc_fall && armed_q) state_d = StActive;
         end
         StActive: begin
            if (sck_rise) begin
               shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            // The final sck edge wins over a coincident nc rise.
            if (sck_rise && (cnt_q == CNT_LAST)) begin
               commit_d = 1'b1;
               state_d  = nc_rise ? StIdle : StDone;
            end else if (nc_rise) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               state_d     = StIdle;
            end
         end
         StDone: begin
            if (sck_rise) frame_err_d = 1'b1;
            // A fall here means nc pulsed high faster than the synchronizer resolved.
            if (nc_fall) begin
               cnt_d   = '0;
               state_d = StActive;
            end else if (nc_rise) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shreg_q     <= '0;
         commit_q    <= 1'b0;
         frame_err_q <= 1'b0;
         flush_q     <= '0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         commit_q    <= commit_d;
         frame_err_q <= frame_err_d;
         flush_q     <= flush_d;
         armed_q     <= armed_d;
      end
   end

   // Output word register; a commit landing on an accept reloads without overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else if (commit_q) begin
         if (rx_valid_q && !rx_ready) begin
            overrun_q <= 1'b1;
         end else begin
            rx_data_q  <= shreg_q;
            rx_valid_q <= 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_q <= 1'b0;
      end
   end

   always_comb begin
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      frame_err = frame_err_q;
      overrun   = overrun_q;
   end

   logic unused_ok;
   assign unused_ok = sck_s ^ sck_fall ^ CPHA;

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

   logic        clk = 1'b0;
   logic        rst, sck, mosi, nc, rx_ready;
   logic [11:0] rx_data;
   logic        rx_valid, frame_err, overrun;

   always #5 clk = ~clk;

   spi_slave_rx #(.FRAME_BITS(16), .DATA_W(12), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .mosi      (mosi),
      .nc        (nc),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   int   cyc = 0;
   int   vcyc_tot = 0;
   int   err_tot = 0;
   int   valid_rise_cyc = 0;
   logic valid_prev = 1'b0;
   int   last_rise_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) vcyc_tot <= vcyc_tot + 1;
      if (frame_err) err_tot <= err_tot + 1;
      if (rx_valid && !valid_prev) valid_rise_cyc <= cyc;
      valid_prev <= rx_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mode 3: data changes on the falling edge, sampled on the rising edge.
   task automatic send_bits(input logic [15:0] w, input int first, input int count);
      for (int i = first; i < first + count; i++) begin
         sck  = 1'b0;
         mosi = (i < 16) ? w[4'(15 - i)] : 1'b0;
         clk_wait(4);
         sck = 1'b1;
         last_rise_cyc = cyc;
         clk_wait(4);
      end
   endtask

   task automatic frame(input logic [15:0] w, input int nbits);
      nc = 1'b0;
      clk_wait(4);
      send_bits(w, 0, nbits);
      nc = 1'b1;
      clk_wait(12);
   endtask

   typedef struct {
      logic [15:0] word;
      int          nbits;
      logic        ready;
      logic [11:0] exp_data;
      logic        exp_valid;
      int          exp_vcyc;
      int          exp_err;
      logic        exp_ovr;
   } vec_t;

   vec_t vecs[5];
   int   vb, eb;

   initial begin
      vecs[0] = '{16'hF5A3, 16, 1'b1, 12'h5A3, 1'b0, 1, 0, 1'b0};
      vecs[1] = '{16'h0123,  9, 1'b1, 12'h5A3, 1'b0, 0, 1, 1'b0};
      vecs[2] = '{16'h0FFF, 16, 1'b1, 12'hFFF, 1'b0, 1, 0, 1'b0};
      vecs[3] = '{16'h0C3C, 17, 1'b1, 12'hC3C, 1'b0, 1, 1, 1'b0};
      vecs[4] = '{16'hABCD, 16, 1'b1, 12'hBCD, 1'b0, 1, 0, 1'b0};

      rst = 1'b1; sck = 1'b1; mosi = 1'b0; nc = 1'b1; rx_ready = 1'b0;
      clk_wait(3);
      check("reset rx_data", 32'(rx_data), 32'h0);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      rst = 1'b0;
      clk_wait(10);

      for (int v = 0; v < 5; v++) begin
         rx_ready = vecs[v].ready;
         vb = vcyc_tot;
         eb = err_tot;
         frame(vecs[v].word, vecs[v].nbits);
         check($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d rx_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d valid cycles", v), 32'(vcyc_tot - vb), 32'(vecs[v].exp_vcyc));
         check($sformatf("vec%0d frame_err pulses", v), 32'(err_tot - eb),
               32'(vecs[v].exp_err));
         check($sformatf("vec%0d overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
      end
      check("commit latency", 32'(valid_rise_cyc - last_rise_cyc), 32'd4);

      // Back-to-back frames with nothing accepted: first word held, overrun set.
      rx_ready = 1'b0;
      frame(16'h0123, 16);
      check("b2b first rx_data", 32'(rx_data), 32'h123);
      check("b2b first overrun", 32'(overrun), 32'h0);
      frame(16'h0ABC, 16);
      check("b2b held rx_data", 32'(rx_data), 32'h123);
      check("b2b rx_valid", 32'(rx_valid), 32'h1);
      check("b2b overrun", 32'(overrun), 32'h1);
      rx_ready = 1'b1;
      clk_wait(1);
      rx_ready = 1'b0;
      clk_wait(1);
      check("b2b accept drops valid", 32'(rx_valid), 32'h0);

      // Reset in the middle of a frame; the rest of that frame must be ignored.
      nc = 1'b0;
      clk_wait(4);
      send_bits(16'h0F0F, 0, 6);
      rst = 1'b1;
      clk_wait(3);
      rst = 1'b0;
      clk_wait(2);
      check("midrst rx_data", 32'(rx_data), 32'h0);
      check("midrst rx_valid", 32'(rx_valid), 32'h0);
      check("midrst overrun", 32'(overrun), 32'h0);
      vb = vcyc_tot;
      eb = err_tot;
      send_bits(16'h0F0F, 6, 10);
      nc = 1'b1;
      clk_wait(12);
      check("midrst tail valid cycles", 32'(vcyc_tot - vb), 32'h0);
      check("midrst tail frame_err", 32'(err_tot - eb), 32'h0);
      frame(16'h0555, 16);
      check("post-rst rx_data", 32'(rx_data), 32'h555);
      check("post-rst rx_valid", 32'(rx_valid), 32'h1);

      // sck activity with nc high must not capture anything.
      eb = err_tot;
      for (int i = 0; i < 8; i++) begin
         sck = 1'b0; mosi = 1'b1; clk_wait(4);
         sck = 1'b1; clk_wait(4);
      end
      clk_wait(8);
      check("nc-high rx_data", 32'(rx_data), 32'h555);
      check("nc-high overrun", 32'(overrun), 32'h0);
      check("nc-high frame_err", 32'(err_tot - eb), 32'h0);

      // Commit coincident with accept of the held word: new word loads, no overrun.
      nc = 1'b0;
      clk_wait(4);
      send_bits(16'h0321, 0, 15);
      sck  = 1'b0;
      mosi = 1'b1;
      clk_wait(4);
      sck = 1'b1;
      clk_wait(3);
      rx_ready = 1'b1;
      clk_wait(1);
      rx_ready = 1'b0;
      check("coincide rx_data", 32'(rx_data), 32'h321);
      check("coincide rx_valid", 32'(rx_valid), 32'h1);
      clk_wait(4);
      nc = 1'b1;
      clk_wait(12);
      check("coincide valid held", 32'(rx_valid), 32'h1);
      check("coincide overrun", 32'(overrun), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
